frame_tx_1011: RTL and testbench
================================

FRAME_TX_1011 -- requirements
Module: frame_tx_1011

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all ports are named in capitals (CLK, RST).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the payload width in bits; legal range is 1..32.
REQ-003 The block SHALL have parameter PREAMBLE, default 4'b1011, giving the 4-bit sync pattern, sent MSB first.
REQ-004 The block SHALL have parameter GAP_LEN, default 1, giving the number of idle 0 bits after each payload; legal range is 1..15.
REQ-005 CLK  input  1  clock; all state changes occur on the rising edge.
REQ-006 RST  input  1  synchronous active-high reset, sampled on the rising edge of CLK.
REQ-007 DIN  input  DATA_W  payload word, sampled only on accept.
REQ-008 LOAD  input  1  request to send DIN.
REQ-009 READY  output  1  high when the block can accept a frame.
REQ-010 OUT  output  1  registered serial bit stream.
REQ-011 BUSY  output  1  high while a frame is in progress; equals ~READY.
REQ-012 DONE  output  1  one-cycle pulse marking frame completion.
REQ-013 FRAME_CNT  output  8  count of completed frames.

Function
REQ-014 The FSM SHALL have four states: IDLE, SYNC, DATA and GAP.
REQ-015 READY SHALL be high only in IDLE.
REQ-016 Accept SHALL occur at a rising edge where LOAD=1, READY=1 and RST=0; DIN is captured into a shift register at that edge.
REQ-017 IDLE -> SYNC SHALL happen on accept; otherwise the FSM stays in IDLE with OUT=0.
REQ-018 SYNC SHALL drive PREAMBLE[3], [2], [1], [0] on OUT in the 4 cycles after accept (1,0,1,1 by default), then move to DATA.
REQ-019 DATA SHALL drive the captured payload MSB first for DATA_W cycles, then move to GAP.
REQ-020 GAP SHALL drive OUT=0 for GAP_LEN cycles, then move to IDLE.
REQ-021 Frame length SHALL be 4+DATA_W+GAP_LEN cycles; READY SHALL return high at the edge that ends the last GAP cycle.
REQ-022 DONE SHALL be high for exactly the first GAP cycle of each frame.
REQ-023 FRAME_CNT SHALL increment by 1 at the edge entering GAP, and SHALL wrap from 255 to 0.
REQ-024 The block SHALL ignore LOAD and DIN while BUSY; a request held high SHALL be accepted at the first edge where READY=1.
REQ-025 With LOAD held high continuously, frames SHALL be sent back to back, separated by exactly GAP_LEN zeros, with no extra idle cycle.
REQ-026 A change on DIN after accept SHALL NOT affect the frame in flight.
REQ-027 OUT, READY, BUSY and DONE SHALL be glitch-free state/register outputs; there SHALL be no combinational path from LOAD or DIN to OUT.

Reset
REQ-028 At any edge with RST=1, the block SHALL go to IDLE and drive OUT=0, READY=1, BUSY=0, DONE=0, FRAME_CNT=0, and clear the shift register.
REQ-029 RST SHALL take priority over accept, and a reset mid-frame SHALL abandon the frame without asserting DONE.
REQ-030 The edge after RST deasserts SHALL be able to accept a frame.

Verification
REQ-031 Reset, then LOAD=1 for 1 cycle with DIN=8'hA5 -> OUT over the next 13 cycles = 1011 10100101 0; DONE high in cycle 13 only; FRAME_CNT=1; READY high after cycle 13.
REQ-032 LOAD held high with DIN=8'hFF, then 8'h00 -> two frames 1011 11111111 0 1011 00000000 0, back to back; DONE pulses exactly 13 cycles apart.
REQ-033 LOAD pulsed with DIN=8'h3C during cycle 5 of an active frame -> ignored; the active frame is unchanged and no second frame starts.
REQ-034 RST=1 during DATA bit 3 -> at the next edge OUT=0 and READY=1; no DONE; FRAME_CNT=0; a new frame sent immediately after is correct.
REQ-035 Send 257 frames -> FRAME_CNT reads 255, then 0, then 1.
REQ-036 Loop OUT into the team's 1011 Mealy non-overlapping detector with random payloads -> at least one detection per frame, aligned with the end of the preamble.

Source files
------------

// File: rtl/frame_tx_1011.sv
// Serial frame transmitter: 4-bit preamble, DATA_W-bit payload (MSB first),
// then GAP_LEN idle zeros. All outputs are registered.
module frame_tx_1011 #(
  parameter int unsigned DATA_W   = 8,
  parameter logic [3:0]  PREAMBLE = 4'b1011,
  parameter int unsigned GAP_LEN  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DIN,
  input  logic              LOAD,
  output logic              READY,
  output logic              OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic [7:0]        FRAME_CNT
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                out_q, out_d;
  logic                ready_q, ready_d;
  logic                busy_q;
  logic                done_q, done_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic [1:0]          pidx;

  // State and output registers; reset forces idle and clears the payload.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      out_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      out_q       <= out_d;
      ready_q     <= ready_d;
      busy_q      <= ~ready_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state and next-output logic. cnt_q counts the cycles left in the
  // current state after this one. A request seen in the final gap cycle
  // starts the next frame directly, so held LOAD gives back-to-back frames.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    out_d       = 1'b0;
    ready_d     = 1'b0;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    pidx        = 2'(cnt_q - CNT_W'(1));

    unique case (state_q)
      IDLE: begin
        if (LOAD) begin
          state_d = SYNC;
          sh_d    = DIN;
          out_d   = PREAMBLE[3];
          cnt_d   = CNT_W'(3);
        end else begin
          ready_d = 1'b1;
        end
      end

      SYNC: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          out_d   = sh_q[DATA_W-1];
          sh_d    = sh_q << 1;
          cnt_d   = CNT_W'(DATA_W - 1);
        end else begin
          out_d = PREAMBLE[pidx];
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == '0) begin
          state_d     = GAP;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
          cnt_d       = CNT_W'(GAP_LEN - 1);
        end else begin
          out_d = sh_q[DATA_W-1];
          sh_d  = sh_q << 1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_q == '0) begin
          if (LOAD) begin
            state_d = SYNC;
            sh_d    = DIN;
            out_d   = PREAMBLE[3];
            cnt_d   = CNT_W'(3);
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign READY     = ready_q;
  assign BUSY      = busy_q;
  assign OUT       = out_q;
  assign DONE      = done_q;
  assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_frame_tx_1011.sv
// Directed bench for frame_tx_1011 with default parameters.
module tb_frame_tx_1011;

  logic       CLK = 1'b0;
  logic       RST;
  logic       LOAD;
  logic [7:0] DIN;
  logic       READY, OUT, BUSY, DONE;
  logic [7:0] FRAME_CNT;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  int ds       = 0;
  int done_cyc = 0;

  frame_tx_1011 #(.DATA_W(8), .PREAMBLE(4'b1011), .GAP_LEN(1)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .LOAD(LOAD), .READY(READY),
    .OUT(OUT), .BUSY(BUSY), .DONE(DONE), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  // One clock, then settle at the falling edge.
  task automatic step;
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Mealy non-overlapping 1011 detector reference.
  task automatic det_step(input logic b, output bit hit);
    hit = 1'b0;
    case (ds)
      0: ds = b ? 1 : 0;
      1: ds = b ? 1 : 2;
      2: ds = b ? 3 : 0;
      default: begin
        if (b) begin hit = 1'b1; ds = 0; end
        else ds = 2;
      end
    endcase
  endtask

  // Checks the 13 cycles of a frame starting in its first cycle.
  // mode 0: drop LOAD; mode 1: keep LOAD high; mode 2: drop, then pulse in cycle 5.
  task automatic frame_chk(input logic [7:0] d, input int mode);
    logic [12:0] e;
    bit hit;
    e = {4'b1011, d, 1'b0};
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("out d=%0h k=%0d", d, k), 32'(OUT), 32'(e[12]));
      chk($sformatf("done d=%0h k=%0d", d, k), 32'(DONE), 32'(k == 13));
      chk($sformatf("ready d=%0h k=%0d", d, k), 32'(READY), 32'd0);
      chk($sformatf("busy d=%0h k=%0d", d, k), 32'(BUSY), 32'd1);
      det_step(OUT, hit);
      if (k == 4) chk($sformatf("det d=%0h", d), 32'(hit), 32'd1);
      if (DONE) done_cyc = cyc;
      e = e << 1;
      if (k == 1 && mode != 1) LOAD = 1'b0;
      if (mode == 2 && k == 5) begin LOAD = 1'b1; DIN = 8'h3C; end
      if (mode == 2 && k == 6) LOAD = 1'b0;
      step();
    end
  endtask

  initial begin
    int d1;
    logic [7:0] cur, nxt;
    RST = 1'b1; LOAD = 1'b1; DIN = 8'hA5;
    @(negedge CLK);
    step();
    chk("rst ready", 32'(READY), 32'd1);
    chk("rst out", 32'(OUT), 32'd0);
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst done", 32'(DONE), 32'd0);
    chk("rst cnt", 32'(FRAME_CNT), 32'd0);

    // Single frame of A5; DIN changes after accept.
    RST = 1'b0;
    step();
    DIN = 8'h5A;
    frame_chk(8'hA5, 0);
    chk("a5 ready after", 32'(READY), 32'd1);
    chk("a5 busy after", 32'(BUSY), 32'd0);
    chk("a5 cnt", 32'(FRAME_CNT), 32'd1);
    chk("a5 out after", 32'(OUT), 32'd0);

    // Back-to-back FF then 00 with LOAD held.
    LOAD = 1'b1; DIN = 8'hFF;
    step();
    DIN = 8'h00;
    frame_chk(8'hFF, 1);
    d1 = done_cyc;
    frame_chk(8'h00, 0);
    chk("done spacing", 32'(done_cyc - d1), 32'd13);
    chk("b2b cnt", 32'(FRAME_CNT), 32'd3);
    chk("b2b ready", 32'(READY), 32'd1);

    // LOAD pulse in cycle 5 of an active frame is ignored.
    LOAD = 1'b1; DIN = 8'hC3;
    step();
    frame_chk(8'hC3, 2);
    chk("inj ready", 32'(READY), 32'd1);
    chk("inj cnt", 32'(FRAME_CNT), 32'd4);
    step();
    chk("inj idle out", 32'(OUT), 32'd0);
    chk("inj idle ready", 32'(READY), 32'd1);
    chk("inj idle busy", 32'(BUSY), 32'd0);

    // Reset during the third payload bit abandons the frame.
    LOAD = 1'b1; DIN = 8'h96;
    step();
    LOAD = 1'b0;
    repeat (6) step();
    chk("mid busy", 32'(BUSY), 32'd1);
    chk("mid bit3", 32'(OUT), 32'd0);
    RST = 1'b1;
    step();
    chk("mid rst out", 32'(OUT), 32'd0);
    chk("mid rst ready", 32'(READY), 32'd1);
    chk("mid rst busy", 32'(BUSY), 32'd0);
    chk("mid rst done", 32'(DONE), 32'd0);
    chk("mid rst cnt", 32'(FRAME_CNT), 32'd0);
    RST = 1'b0; ds = 0;
    LOAD = 1'b1; DIN = 8'h69;
    step();
    frame_chk(8'h69, 0);
    chk("post rst cnt", 32'(FRAME_CNT), 32'd1);

    // 257 frames: counter reads 255, then wraps to 0, then 1.
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int i = 0; i < 257; i++) begin
      LOAD = 1'b1; DIN = 8'($urandom);
      step();
      LOAD = 1'b0;
      repeat (13) step();
      if (i == 254) chk("cnt 255", 32'(FRAME_CNT), 32'd255);
      if (i == 255) chk("cnt wrap 0", 32'(FRAME_CNT), 32'd0);
      if (i == 256) chk("cnt wrap 1", 32'(FRAME_CNT), 32'd1);
    end

    // Random back-to-back payloads through the detector reference.
    ds = 0;
    cur = 8'($urandom);
    LOAD = 1'b1; DIN = cur;
    step();
    for (int f = 0; f < 4; f++) begin
      nxt = 8'($urandom);
      DIN = nxt;
      frame_chk(cur, (f < 3) ? 1 : 0);
      cur = nxt;
    end
    chk("rand ready", 32'(READY), 32'd1);
    chk("rand cnt", 32'(FRAME_CNT), 32'd5);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
